alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares the single-cycle ALU between two requesters, e.g. the main datapath (port 0) and a secondary execution/address unit (port 1).
- Arbitrates each cycle with round-robin or fixed priority, drives the ALU operand/control inputs from the granted requester, and registers the ALU result into a one-entry response buffer with a valid/ready handshake and requester ID.
- Result latency is 1 cycle from grant.

Parameters:
PRIO_MODE, 0, 0 = round-robin between ports; 1 = fixed priority, port 0 always wins
CNT_W, 16, width of per-port saturating grant counters

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
req0_valid  input  1  port 0 operation request
req0_ready  output  1  port 0 request accepted this cycle
req0_in1  input  32  port 0 operand 1
req0_in2  input  32  port 0 operand 2
req0_ctrl  input  4  port 0 ALU op code (define.v encodings: `AND, `OR, `ADD, `SUB, `SLT, `EQ, `SLL, `SRL)
req0_shamt  input  5  port 0 shift amount
req1_valid / req1_ready / req1_in1 / req1_in2 / req1_ctrl / req1_shamt  same as port 0, for port 1
alu_in1  output  32  to ALU in1
alu_in2  output  32  to ALU in2
alu_ctrl  output  4  to ALU ctrl
alu_shamt  output  5  to ALU shamt
alu_out  input  32  from ALU out
alu_zero  input  1  from ALU zero
rsp_valid  output  1  response buffer holds a result
rsp_ready  input  1  consumer accepts response
rsp_data  output  32  registered ALU result
rsp_zero  output  1  registered ALU zero flag
rsp_id  output  1  requester that issued the result
gnt_cnt0  output  CNT_W  saturating count of port 0 grants
gnt_cnt1  output  CNT_W  saturating count of port 1 grants

Behaviour:
- Reset: synchronous on rising clk when rst_n=0. Values after reset:
  - rsp_valid=0, rsp_data=0, rsp_zero=0, rsp_id=0
  - gnt_cnt0=gnt_cnt1=0
  - last_grant pointer=1, so port 0 wins the first contention
  - Reset mid-transaction discards the buffered response; no grant occurs in the reset cycle.
- can_accept = !rsp_valid | rsp_ready. This is combinational; a grant may refill the buffer in the same cycle it drains.
- Grant selection when can_accept=1:
  - only one valid -> that port.
  - both valid, PRIO_MODE=0 -> the port != last_grant.
  - both valid, PRIO_MODE=1 -> port 0.
  - none valid -> no grant.
- When can_accept=0: no grant, and both readys are 0.
- reqN_ready=1 exactly in the cycle port N is granted; at most one ready high per cycle. readys are combinational from the valids and can_accept.
- ALU drive (combinational):
  - granted port's in1/in2/ctrl/shamt -> alu_*.
  - no grant -> all alu_* driven to 0.
- On grant, at the clock edge:
  - rsp_data<=alu_out, rsp_zero<=alu_zero, rsp_id<=granted port, rsp_valid<=1.
  - last_grant<=granted port.
  - gnt_cntN increments, saturating at all-ones.
- Without a grant: if rsp_valid & rsp_ready, then rsp_valid<=0 and rsp_data/zero/id hold their last values.
- Response stability: while rsp_valid=1 and rsp_ready=0, rsp_data/zero/id remain stable.
- Requesters must hold operands stable while valid=1 and ready=0. The arbiter does not latch operands.
- last_grant updates only on a grant. An idle cycle does not reset fairness.
- Throughput: 1 op/cycle when rsp_ready is held 1.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then no valids -> rsp_valid=0, alu_in1/in2/ctrl/shamt=0, counters 0, both readys 0.
- Single request: req0 `ADD in1=32'h0000_00FF, in2=32'h0000_0001 -> req0_ready=1 same cycle; next cycle rsp_valid=1, rsp_data=32'h100, rsp_zero=0, rsp_id=0.
- Contention round-robin (PRIO_MODE=0): both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; req0 `SUB 5-5 yields rsp_zero=1, id=0; req1 `SLL in2=1, shamt=4 yields rsp_data=16, id=1; gnt_cnt0=gnt_cnt1 after an even number of cycles.
- Fixed priority (PRIO_MODE=1): both valid for 4 cycles -> port 0 granted every cycle, req1_ready=0, gnt_cnt1=0.
- Backpressure: rsp_ready=0 with a buffered result and both requesters valid -> readys 0 and rsp_data stable for 3 cycles; raise rsp_ready -> same-cycle grant; buffer refilled with no bubble.
- Reset mid-operation and saturation:
  - rst_n=0 while rsp_valid=1 -> rsp_valid=0 next cycle.
  - CNT_W=2 with 5 port-0 grants -> gnt_cnt0=3.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Shares one single-cycle ALU between two requesters and buffers its result
// in a one-entry response register with a valid/ready handshake and requester ID.
//
// state     | meaning
// BUF_EMPTY | no result held; any valid request may be granted
// BUF_FULL  | result held; a new grant needs rsp_ready in the same cycle
module alu_share_arbiter #(
   parameter int PRIO_MODE = 0,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [31:0]      req0_in1,
   input  logic [31:0]      req0_in2,
   input  logic [3:0]       req0_ctrl,
   input  logic [4:0]       req0_shamt,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [31:0]      req1_in1,
   input  logic [31:0]      req1_in2,
   input  logic [3:0]       req1_ctrl,
   input  logic [4:0]       req1_shamt,
   output logic [31:0]      alu_in1,
   output logic [31:0]      alu_in2,
   output logic [3:0]       alu_ctrl,
   output logic [4:0]       alu_shamt,
   input  logic [31:0]      alu_out,
   input  logic             alu_zero,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_data,
   output logic             rsp_zero,
   output logic             rsp_id,
   output logic [CNT_W-1:0] gnt_cnt0,
   output logic [CNT_W-1:0] gnt_cnt1
);

   typedef enum logic {BUF_EMPTY = 1'b0, BUF_FULL = 1'b1} buf_state_e;

   buf_state_e       state_q, state_d;
   logic [31:0]      rsp_data_q, rsp_data_d;
   logic             rsp_zero_q, rsp_zero_d;
   logic             rsp_id_q, rsp_id_d;
   logic             last_grant_q, last_grant_d;
   logic [CNT_W-1:0] gnt_cnt0_q, gnt_cnt0_d;
   logic [CNT_W-1:0] gnt_cnt1_q, gnt_cnt1_d;

   logic can_accept;
   logic gnt0;
   logic gnt1;

   // Gating with rst_n keeps the reset cycle free of grants and readys.
   always_comb begin
      can_accept = rst_n & ((state_q == BUF_EMPTY) | rsp_ready);
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (can_accept) begin
         if (req0_valid && req1_valid) begin
            if (PRIO_MODE == 1) begin
               gnt0 = 1'b1;
            end else if (last_grant_q) begin
               gnt0 = 1'b1;
            end else begin
               gnt1 = 1'b1;
            end
         end else begin
            gnt0 = req0_valid;
            gnt1 = req1_valid;
         end
      end
   end

   always_comb begin
      alu_in1   = '0;
      alu_in2   = '0;
      alu_ctrl  = '0;
      alu_shamt = '0;
      if (gnt0) begin
         alu_in1   = req0_in1;
         alu_in2   = req0_in2;
         alu_ctrl  = req0_ctrl;
         alu_shamt = req0_shamt;
      end else if (gnt1) begin
         alu_in1   = req1_in1;
         alu_in2   = req1_in2;
         alu_ctrl  = req1_ctrl;
         alu_shamt = req1_shamt;
      end
   end

   always_comb begin
      state_d      = state_q;
      rsp_data_d   = rsp_data_q;
      rsp_zero_d   = rsp_zero_q;
      rsp_id_d     = rsp_id_q;
      last_grant_d = last_grant_q;
      gnt_cnt0_d   = gnt_cnt0_q;
      gnt_cnt1_d   = gnt_cnt1_q;
      if (gnt0 || gnt1) begin
         state_d      = BUF_FULL;
         rsp_data_d   = alu_out;
         rsp_zero_d   = alu_zero;
         rsp_id_d     = gnt1;
         last_grant_d = gnt1;
      end else if ((state_q == BUF_FULL) && rsp_ready) begin
         state_d = BUF_EMPTY;
      end
      if (gnt0 && (gnt_cnt0_q != {CNT_W{1'b1}})) begin
         gnt_cnt0_d = gnt_cnt0_q + CNT_W'(1);
      end
      if (gnt1 && (gnt_cnt1_q != {CNT_W{1'b1}})) begin
         gnt_cnt1_d = gnt_cnt1_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= BUF_EMPTY;
         rsp_data_q   <= '0;
         rsp_zero_q   <= 1'b0;
         rsp_id_q     <= 1'b0;
         last_grant_q <= 1'b1;
         gnt_cnt0_q   <= '0;
         gnt_cnt1_q   <= '0;
      end else begin
         state_q      <= state_d;
         rsp_data_q   <= rsp_data_d;
         rsp_zero_q   <= rsp_zero_d;
         rsp_id_q     <= rsp_id_d;
         last_grant_q <= last_grant_d;
         gnt_cnt0_q   <= gnt_cnt0_d;
         gnt_cnt1_q   <= gnt_cnt1_d;
      end
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign rsp_valid  = (state_q == BUF_FULL);
   assign rsp_data   = rsp_data_q;
   assign rsp_zero   = rsp_zero_q;
   assign rsp_id     = rsp_id_q;
   assign gnt_cnt0   = gnt_cnt0_q;
   assign gnt_cnt1   = gnt_cnt1_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: three instances (round-robin, fixed priority,
// 2-bit counters) share one stimulus stream and are checked against a reference model.
module tb_alu_share_arbiter;

   localparam logic [3:0] C_AND = 4'd0, C_OR = 4'd1, C_ADD = 4'd2, C_SUB = 4'd3,
                          C_SLT = 4'd4, C_EQ = 4'd5, C_SLL = 4'd6, C_SRL = 4'd7;
   localparam int NI = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        v0 = 1'b0, v1 = 1'b0, rr = 1'b0;
   logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
   logic [3:0]  c0 = '0, c1 = '0;
   logic [4:0]  s0 = '0, s1 = '0;

   logic        r0 [NI];
   logic        r1 [NI];
   logic [31:0] ai1 [NI];
   logic [31:0] ai2 [NI];
   logic [3:0]  actl [NI];
   logic [4:0]  ash [NI];
   logic [31:0] aout [NI];
   logic        azero [NI];
   logic        rv [NI];
   logic [31:0] rdata [NI];
   logic        rzero [NI];
   logic        rid [NI];
   logic [15:0] cnt0 [NI];
   logic [15:0] cnt1 [NI];

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_fn(logic [3:0] c, logic [31:0] a, logic [31:0] b,
                                          logic [4:0] s);
      case (c)
         C_AND:   return a & b;
         C_OR:    return a | b;
         C_ADD:   return a + b;
         C_SUB:   return a - b;
         C_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         C_EQ:    return (a == b) ? 32'd1 : 32'd0;
         C_SLL:   return b << s;
         C_SRL:   return b >> s;
         default: return 32'd0;
      endcase
   endfunction

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int CW = (g == 2) ? 2 : 16;
      logic [CW-1:0] c0w, c1w;
      assign aout[g]  = alu_fn(actl[g], ai1[g], ai2[g], ash[g]);
      assign azero[g] = (aout[g] == 32'd0);
      assign cnt0[g]  = 16'(c0w);
      assign cnt1[g]  = 16'(c1w);
      alu_share_arbiter #(.PRIO_MODE((g == 1) ? 1 : 0), .CNT_W(CW)) u_dut (
         .clk(clk), .rst_n(rst_n),
         .req0_valid(v0), .req0_ready(r0[g]), .req0_in1(a0), .req0_in2(b0),
         .req0_ctrl(c0), .req0_shamt(s0),
         .req1_valid(v1), .req1_ready(r1[g]), .req1_in1(a1), .req1_in2(b1),
         .req1_ctrl(c1), .req1_shamt(s1),
         .alu_in1(ai1[g]), .alu_in2(ai2[g]), .alu_ctrl(actl[g]), .alu_shamt(ash[g]),
         .alu_out(aout[g]), .alu_zero(azero[g]),
         .rsp_valid(rv[g]), .rsp_ready(rr), .rsp_data(rdata[g]), .rsp_zero(rzero[g]),
         .rsp_id(rid[g]), .gnt_cnt0(c0w), .gnt_cnt1(c1w)
      );
   end

   // Reference model state, one slot per instance.
   int          m_mode [NI] = '{0, 1, 0};
   int          m_cmax [NI] = '{65535, 65535, 3};
   bit          m_full [NI];
   logic [31:0] m_data [NI];
   bit          m_zero [NI];
   bit          m_id [NI];
   int          m_last [NI];
   int          m_cnt [NI][2];
   int          m_w [NI];

   task automatic chk1(string name, int g, logic act, logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[inst%0d] got=%b want=%b t=%0t", name, g, act, exp, $time);
      end
   endtask

   task automatic chk32(string name, int g, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[inst%0d] got=%h want=%h t=%0t", name, g, act, exp, $time);
      end
   endtask

   // Settle combinational paths, predict the winner and check readys / ALU drive.
   task automatic step_pre();
      #1;
      for (int g = 0; g < NI; g++) begin
         logic [31:0] e1, e2;
         logic [3:0]  ec;
         logic [4:0]  es;
         m_w[g] = -1;
         if (rst_n && (!m_full[g] || rr)) begin
            if (v0 && v1) m_w[g] = (m_mode[g] == 1) ? 0 : 1 - m_last[g];
            else if (v0)  m_w[g] = 0;
            else if (v1)  m_w[g] = 1;
         end
         e1 = '0; e2 = '0; ec = '0; es = '0;
         if (m_w[g] == 0) begin e1 = a0; e2 = b0; ec = c0; es = s0; end
         if (m_w[g] == 1) begin e1 = a1; e2 = b1; ec = c1; es = s1; end
         chk1("req0_ready", g, r0[g], m_w[g] == 0);
         chk1("req1_ready", g, r1[g], m_w[g] == 1);
         chk32("alu_in1", g, ai1[g], e1);
         chk32("alu_in2", g, ai2[g], e2);
         chk32("alu_ctrl", g, 32'(actl[g]), 32'(ec));
         chk32("alu_shamt", g, 32'(ash[g]), 32'(es));
      end
   endtask

   // Clock edge, advance the model, check the registered outputs.
   task automatic step_post();
      @(posedge clk);
      for (int g = 0; g < NI; g++) begin
         if (!rst_n) begin
            m_full[g] = 0; m_data[g] = '0; m_zero[g] = 0; m_id[g] = 0;
            m_last[g] = 1; m_cnt[g][0] = 0; m_cnt[g][1] = 0;
         end else if (m_w[g] >= 0) begin
            m_full[g] = 1;
            m_data[g] = (m_w[g] == 0) ? alu_fn(c0, a0, b0, s0) : alu_fn(c1, a1, b1, s1);
            m_zero[g] = (m_data[g] == 0);
            m_id[g]   = (m_w[g] == 1);
            m_last[g] = m_w[g];
            if (m_cnt[g][m_w[g]] < m_cmax[g]) m_cnt[g][m_w[g]]++;
         end else if (m_full[g] && rr) begin
            m_full[g] = 0;
         end
      end
      #1;
      for (int g = 0; g < NI; g++) begin
         chk1("rsp_valid", g, rv[g], m_full[g]);
         chk32("rsp_data", g, rdata[g], m_data[g]);
         chk1("rsp_zero", g, rzero[g], m_zero[g]);
         chk1("rsp_id", g, rid[g], m_id[g]);
         chk32("gnt_cnt0", g, 32'(cnt0[g]), 32'(m_cnt[g][0]));
         chk32("gnt_cnt1", g, 32'(cnt1[g]), 32'(m_cnt[g][1]));
      end
   endtask

   task automatic step();
      step_pre();
      step_post();
   endtask

   task automatic drive(logic rs, logic x0, logic x1, logic rdy);
      rst_n = rs; v0 = x0; v1 = x1; rr = rdy;
   endtask

   typedef struct {
      logic        rs, x0, x1, rdy;
      logic [3:0]  op0c;
      logic [31:0] op0a, op0b;
      logic [4:0]  op0s;
      logic [3:0]  op1c;
      logic [31:0] op1a, op1b;
      logic [4:0]  op1s;
      logic        e_r0, e_r1, e_rv;
      logic [31:0] e_data;
      logic        e_id, e_zero;
   } vec_t;

   vec_t tbl [15];

   initial begin
      // Hand-derived expectations for the round-robin instance (inst0).
      tbl[0]  = '{0,0,0,0, C_ADD,32'hFF,32'h1,5'd0, C_SLL,32'h0,32'h1,5'd4, 0,0,0, 32'h0,  0,0};
      tbl[1]  = '{0,1,0,1, C_ADD,32'hFF,32'h1,5'd0, C_SLL,32'h0,32'h1,5'd4, 0,0,0, 32'h0,  0,0};
      tbl[2]  = '{1,0,0,1, C_ADD,32'hFF,32'h1,5'd0, C_SLL,32'h0,32'h1,5'd4, 0,0,0, 32'h0,  0,0};
      tbl[3]  = '{1,1,0,1, C_ADD,32'hFF,32'h1,5'd0, C_SLL,32'h0,32'h1,5'd4, 1,0,1, 32'h100,0,0};
      tbl[4]  = '{1,1,1,1, C_SUB,32'h5,32'h5,5'd0,  C_SLL,32'h0,32'h1,5'd4, 0,1,1, 32'h10, 1,0};
      tbl[5]  = '{1,1,1,1, C_SUB,32'h5,32'h5,5'd0,  C_SLL,32'h0,32'h1,5'd4, 1,0,1, 32'h0,  0,1};
      tbl[6]  = '{1,1,1,1, C_SUB,32'h5,32'h5,5'd0,  C_SLL,32'h0,32'h1,5'd4, 0,1,1, 32'h10, 1,0};
      tbl[7]  = '{1,1,1,1, C_SUB,32'h5,32'h5,5'd0,  C_SLL,32'h0,32'h1,5'd4, 1,0,1, 32'h0,  0,1};
      tbl[8]  = '{1,1,1,0, C_SUB,32'h5,32'h5,5'd0,  C_SLL,32'h0,32'h1,5'd4, 0,0,1, 32'h0,  0,1};
      tbl[9]  = '{1,1,1,0, C_SUB,32'h5,32'h5,5'd0,  C_SLL,32'h0,32'h1,5'd4, 0,0,1, 32'h0,  0,1};
      tbl[10] = '{1,1,1,0, C_SUB,32'h5,32'h5,5'd0,  C_SLL,32'h0,32'h1,5'd4, 0,0,1, 32'h0,  0,1};
      tbl[11] = '{1,1,1,1, C_SUB,32'h5,32'h5,5'd0,  C_SLL,32'h0,32'h1,5'd4, 0,1,1, 32'h10, 1,0};
      tbl[12] = '{1,0,0,1, C_SUB,32'h5,32'h5,5'd0,  C_SLL,32'h0,32'h1,5'd4, 0,0,0, 32'h10, 1,0};
      tbl[13] = '{1,1,0,0, C_ADD,32'hFF,32'h1,5'd0, C_SLL,32'h0,32'h1,5'd4, 1,0,1, 32'h100,0,0};
      tbl[14] = '{0,1,0,0, C_ADD,32'hFF,32'h1,5'd0, C_SLL,32'h0,32'h1,5'd4, 0,0,0, 32'h0,  0,0};

      @(posedge clk);
      #1;
      for (int i = 0; i < 15; i++) begin
         drive(tbl[i].rs, tbl[i].x0, tbl[i].x1, tbl[i].rdy);
         c0 = tbl[i].op0c; a0 = tbl[i].op0a; b0 = tbl[i].op0b; s0 = tbl[i].op0s;
         c1 = tbl[i].op1c; a1 = tbl[i].op1a; b1 = tbl[i].op1b; s1 = tbl[i].op1s;
         step_pre();
         chk1($sformatf("vec%0d_r0", i), 0, r0[0], tbl[i].e_r0);
         chk1($sformatf("vec%0d_r1", i), 0, r1[0], tbl[i].e_r1);
         step_post();
         chk1($sformatf("vec%0d_rv", i), 0, rv[0], tbl[i].e_rv);
         chk32($sformatf("vec%0d_data", i), 0, rdata[0], tbl[i].e_data);
         chk1($sformatf("vec%0d_id", i), 0, rid[0], tbl[i].e_id);
         chk1($sformatf("vec%0d_zero", i), 0, rzero[0], tbl[i].e_zero);
      end

      // Contention from reset: round-robin balances, fixed priority starves port 1.
      drive(0, 0, 0, 1); step(); step();
      drive(1, 1, 1, 1);
      for (int i = 0; i < 4; i++) begin
         step_pre();
         chk1("fp_r0", 1, r0[1], 1'b1);
         chk1("fp_r1", 1, r1[1], 1'b0);
         chk1("rr_alt", 0, r0[0], (i % 2) == 0);
         step_post();
      end
      chk32("rr_cnt0", 0, 32'(cnt0[0]), 32'd2);
      chk32("rr_cnt1", 0, 32'(cnt1[0]), 32'd2);
      chk32("fp_cnt0", 1, 32'(cnt0[1]), 32'd4);
      chk32("fp_cnt1", 1, 32'(cnt1[1]), 32'd0);

      // Saturation of the 2-bit counter after five port-0 grants.
      drive(0, 0, 0, 1); step();
      drive(1, 1, 0, 1);
      for (int i = 0; i < 5; i++) step();
      chk32("sat_cnt0", 2, 32'(cnt0[2]), 32'd3);
      chk32("nosat_cnt0", 0, 32'(cnt0[0]), 32'd5);

      // Mid-transaction reset discards the buffered result.
      drive(1, 0, 0, 0); step();
      chk1("pre_rst_valid", 0, rv[0], 1'b1);
      drive(0, 1, 1, 0); step();
      chk1("post_rst_valid", 0, rv[0], 1'b0);

      // Randomised traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         rst_n = ($urandom_range(0, 63) != 0);
         v0 = 1'($urandom_range(0, 1));
         v1 = 1'($urandom_range(0, 1));
         rr = ($urandom_range(0, 3) != 0);
         c0 = 4'($urandom_range(0, 7));
         c1 = 4'($urandom_range(0, 7));
         a0 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
         b0 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
         a1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
         b1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
         s0 = 5'($urandom_range(0, 31));
         s1 = 5'($urandom_range(0, 31));
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
